// File: rtl/tp1_pkg.sv
// Shared TP1 definitions: loader FSM state encodings and ALU opcodes.
package tp1_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_A  = 2'b00,
      ST_WAIT_B  = 2'b01,
      ST_WAIT_OP = 2'b10,
      ST_READY   = 2'b11
   } state_t;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/tp1_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce counter and a
// single-cycle pulse on each accepted press.
module tp1_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic          r_stable_q;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_q <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync1    <= i_btn;
         r_sync2    <= r_sync1;
         r_stable_q <= r_stable;
         // any return to the stable level restarts the count
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_pulse = r_stable & ~r_stable_q;

endmodule

// File: rtl/tp1_alu_input_loader.sv
// Loads operand A, operand B and the opcode from the shared switch bank,
// one debounced button each, and holds them registered for the TP1 ALU.
//
// state      | meaning
// WAIT_A  00 | waiting for operand A press
// WAIT_B  01 | A loaded, waiting for operand B press
// WAIT_OP 10 | A and B loaded, waiting for opcode press
// READY   11 | full operand set held; A restarts, B/OP reload in place
module tp1_alu_input_loader
   import tp1_pkg::*;
#(
   parameter int N_BUS           = 8,
   parameter int N_OP            = 6,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_BUS-1:0] i_sw,
   input  logic             i_btn_a,
   input  logic             i_btn_b,
   input  logic             i_btn_op,
   output logic [N_BUS-1:0] o_A,
   output logic [N_BUS-1:0] o_B,
   output logic [N_OP-1:0]  o_OP,
   output logic             o_valid,
   output logic [1:0]       o_state
);

   logic w_pulse_a;
   logic w_pulse_b;
   logic w_pulse_op;

   tp1_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_btn_a),
      .o_pulse (w_pulse_a)
   );

   tp1_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_btn_b),
      .o_pulse (w_pulse_b)
   );

   tp1_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_op (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_btn_op),
      .o_pulse (w_pulse_op)
   );

   state_t           r_state;
   state_t           w_next;
   logic             w_ld_a;
   logic             w_ld_b;
   logic             w_ld_op;
   logic [N_BUS-1:0] r_A;
   logic [N_BUS-1:0] r_B;
   logic [N_OP-1:0]  r_OP;
   logic             r_valid;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_WAIT_A;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_WAIT_A:  if (w_pulse_a)  w_next = ST_WAIT_B;
         ST_WAIT_B:  if (w_pulse_b)  w_next = ST_WAIT_OP;
         ST_WAIT_OP: if (w_pulse_op) w_next = ST_READY;
         ST_READY:   if (w_pulse_a)  w_next = ST_WAIT_B;
         default:    w_next = ST_WAIT_A;
      endcase
   end

   // in READY a press on A wins and masks simultaneous B/OP reloads
   always_comb begin
      w_ld_a  = 1'b0;
      w_ld_b  = 1'b0;
      w_ld_op = 1'b0;
      case (r_state)
         ST_WAIT_A:  w_ld_a  = w_pulse_a;
         ST_WAIT_B:  w_ld_b  = w_pulse_b;
         ST_WAIT_OP: w_ld_op = w_pulse_op;
         ST_READY: begin
            w_ld_a  = w_pulse_a;
            w_ld_b  = w_pulse_b  & ~w_pulse_a;
            w_ld_op = w_pulse_op & ~w_pulse_a;
         end
         default: begin
            w_ld_a  = 1'b0;
            w_ld_b  = 1'b0;
            w_ld_op = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_A     <= '0;
         r_B     <= '0;
         r_OP    <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_ld_a)  r_A  <= i_sw;
         if (w_ld_b)  r_B  <= i_sw;
         if (w_ld_op) r_OP <= i_sw[N_OP-1:0];
         r_valid <= (w_next == ST_READY);
      end
   end

   assign o_A     = r_A;
   assign o_B     = r_B;
   assign o_OP    = r_OP;
   assign o_valid = r_valid;
   assign o_state = r_state;

endmodule

// File: tb/tb_tp1_alu_input_loader.sv
// Directed bench for tp1_alu_input_loader with a short debounce window.
module tb_tp1_alu_input_loader;
   import tp1_pkg::*;

   localparam int DB  = 4;
   localparam int LAT = DB + 3;

   logic       clk;
   logic       rst_n;
   logic [7:0] sw;
   logic       btn_a, btn_b, btn_op;
   logic [7:0] o_A, o_B;
   logic [5:0] o_OP;
   logic       o_valid;
   logic [1:0] o_state;

   int errors = 0;
   int checks = 0;

   tp1_alu_input_loader #(.N_BUS(8), .N_OP(6), .DEBOUNCE_CYCLES(DB)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_sw     (sw),
      .i_btn_a  (btn_a),
      .i_btn_b  (btn_b),
      .i_btn_op (btn_op),
      .o_A      (o_A),
      .o_B      (o_B),
      .o_OP     (o_OP),
      .o_valid  (o_valid),
      .o_state  (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       a, b, op;
      logic [7:0] sw;
      logic [7:0] ea, eb;
      logic [5:0] eop;
      logic       ev;
      logic [1:0] est;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                      input logic [5:0] op);
      case (op)
         OP_ADD:  alu = a + b;
         OP_SUB:  alu = a - b;
         OP_AND:  alu = a & b;
         OP_OR:   alu = a | b;
         OP_XOR:  alu = a ^ b;
         OP_NOR:  alu = ~(a | b);
         OP_SRA:  alu = $unsigned($signed(a) >>> b);
         OP_SRL:  alu = a >> b;
         default: alu = 8'h00;
      endcase
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input vec_t e);
      chk({tag, ".A"},     o_A,            e.ea);
      chk({tag, ".B"},     o_B,            e.eb);
      chk({tag, ".OP"},    {2'b00, o_OP},  {2'b00, e.eop});
      chk({tag, ".valid"}, {7'd0, o_valid}, {7'd0, e.ev});
      chk({tag, ".state"}, {6'd0, o_state}, {6'd0, e.est});
   endtask

   function automatic vec_t mk(input logic a, input logic b, input logic op,
                               input logic [7:0] s, input logic [7:0] ea,
                               input logic [7:0] eb, input logic [5:0] eop,
                               input logic ev, input logic [1:0] est);
      vec_t v;
      v.a = a; v.b = b; v.op = op; v.sw = s;
      v.ea = ea; v.eb = eb; v.eop = eop; v.ev = ev; v.est = est;
      return v;
   endfunction

   // Called just after a rising edge: hold the buttons, expect no change
   // through edge LAT-1 and the new values at edge LAT, then release.
   task automatic apply(input string tag, input vec_t v, input vec_t prev);
      sw = v.sw; btn_a = v.a; btn_b = v.b; btn_op = v.op;
      repeat (LAT - 1) @(posedge clk);
      #1 chk_all({tag, ".early"}, prev);
      @(posedge clk);
      #1 chk_all({tag, ".load"}, v);
      btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0; sw = 8'hAA;
      repeat (DB + 4) @(posedge clk);
      #1 chk_all({tag, ".release"}, v);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   vec_t zero, prev, v;

   initial begin
      zero = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 6'h00, 1'b0, 2'b00);
      vecs[0] = mk(0, 1, 1, 8'h7F, 8'h00, 8'h00, 6'h00, 1'b0, 2'b00); // out of order
      vecs[1] = mk(1, 0, 0, 8'h05, 8'h05, 8'h00, 6'h00, 1'b0, 2'b01);
      vecs[2] = mk(1, 0, 0, 8'h33, 8'h05, 8'h00, 6'h00, 1'b0, 2'b01); // A ignored in WAIT_B
      vecs[3] = mk(0, 1, 0, 8'hFD, 8'h05, 8'hFD, 6'h00, 1'b0, 2'b10);
      vecs[4] = mk(0, 0, 1, 8'h20, 8'h05, 8'hFD, 6'h20, 1'b1, 2'b11);
      vecs[5] = mk(0, 1, 1, 8'h03, 8'h05, 8'h03, 6'h03, 1'b1, 2'b11); // simultaneous reload
      vecs[6] = mk(1, 1, 1, 8'h11, 8'h11, 8'h03, 6'h03, 1'b0, 2'b01); // A wins, restart
      vecs[7] = mk(0, 1, 0, 8'h22, 8'h11, 8'h22, 6'h03, 1'b0, 2'b10);
      vecs[8] = mk(0, 0, 1, 8'h25, 8'h11, 8'h22, 6'h25, 1'b1, 2'b11);
      vecs[9] = mk(0, 0, 1, 8'hE6, 8'h11, 8'h22, 6'h26, 1'b1, 2'b11); // OP low bits only

      sw = 8'h00; btn_a = 0; btn_b = 0; btn_op = 0; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_all("reset", zero);
      rst_n = 1'b1;

      prev = zero;
      for (int i = 0; i < 10; i++) begin
         apply($sformatf("vec%0d", i), vecs[i], prev);
         if (i == 4) chk("alu_add", alu(o_A, o_B, o_OP), 8'h02);
         prev = vecs[i];
      end

      // bounce on A: 2-cycle runs never satisfy the debounce window
      pulse_reset();
      chk_all("bounce.reset", zero);
      sw = 8'h5A;
      for (int k = 0; k < 10; k++) begin
         btn_a = (k % 2 == 0);
         repeat (2) @(posedge clk);
         #1 chk($sformatf("bounce.seg%0d.A", k), o_A, 8'h00);
      end
      btn_a = 1'b1;
      repeat (LAT - 1) @(posedge clk);
      #1 chk("bounce.early.A", o_A, 8'h00);
      @(posedge clk);
      #1 chk_all("bounce.load", mk(0, 0, 0, 8'h5A, 8'h5A, 8'h00, 6'h00, 1'b0, 2'b01));
      btn_a = 1'b0;
      repeat (DB + 4) @(posedge clk);
      #1 chk("bounce.once.A", o_A, 8'h5A);

      prev = mk(0, 0, 0, 8'h00, 8'h5A, 8'h00, 6'h00, 1'b0, 2'b01);
      v    = mk(0, 1, 0, 8'h81, 8'h5A, 8'h81, 6'h00, 1'b0, 2'b10);
      apply("pre_rst.b", v, prev);
      prev = v;
      v    = mk(0, 0, 1, 8'h27, 8'h5A, 8'h81, 6'h27, 1'b1, 2'b11);
      apply("pre_rst.op", v, prev);
      chk("alu_nor", alu(o_A, o_B, o_OP), 8'h24);

      // reset in READY while A is mid-debounce and still held afterwards
      sw = 8'h44; btn_a = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("midrst.before.state", {6'd0, o_state}, 8'h03);
      pulse_reset();
      chk_all("midrst.reset", zero);
      repeat (LAT - 1) @(posedge clk);
      #1 chk_all("midrst.early", zero);
      @(posedge clk);
      #1 chk_all("midrst.load", mk(0, 0, 0, 8'h44, 8'h44, 8'h00, 6'h00, 1'b0, 2'b01));
      repeat (DB + 4) @(posedge clk);
      #1 chk("midrst.held.A", o_A, 8'h44);
      chk("midrst.held.state", {6'd0, o_state}, 8'h01);
      btn_a = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
